fadd_sub_norm_round: RTL
========================

Name: fadd_sub_norm_round

Overview:
- Back half of the FP add/sub datapath. Consumes the aligned operands and flags from the extract/align stage.
- Performs magnitude add/sub, normalization, IEEE-754 rounding and packing. Produces the binary32 result and fflags.
- 3-stage valid/ready pipeline between the align stage and FPU writeback.

Parameters:
- LATENCY, 3, number of pipeline stages (fixed; informational only, no other value supported)
- CANON_NAN, 32'h7FC00000, NaN result pattern

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand bundle valid
- in_ready  out  1  stage can accept bundle
- rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; others treated as RNE
- sign1  in  1  operand-1 sign
- sign2  in  1  operand-2 effective sign (already XORed with add_sub)
- exp_res  in  8  common aligned exponent
- mantissa1_aligned  in  48  bit47 carry room, bit46 hidden, [45:23] fraction, [22:0] shifted-out bits
- mantissa2_aligned  in  48  same format
- NaN  in  1  either operand NaN
- inf1  in  1  operand 1 infinite
- inf2  in  1  operand 2 infinite
- zero  in  1  either operand zero
- res_zero  in  1  exact cancellation detected upstream
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  32  packed binary32
- fflags  out  5  {NV,DZ,OF,UF,NX}; DZ is always 0

Behaviour:
- Reset (async, reset_n=0): all stage valids = 0; result = 0; fflags = 0; out_valid = 0. Reset asserted mid-operation discards all in-flight bundles.
- Global advance = !out_valid || out_ready. All stages shift together on advance. in_ready = advance.
- Accept on in_valid && in_ready. rm travels with the data.
- Latency is exactly 3 cycles when there is no stall. Throughput is 1 per cycle.
- While stalled (out_valid && !out_ready), every stage holds and result/fflags are stable. No bundle is lost or duplicated.
- S1 (add):
  - If sign1 == sign2: sum = m1 + m2 (48-bit), res_sign = sign1.
  - Else: sum = larger − smaller, res_sign = sign of the larger magnitude.
  - If magnitudes are equal: sum = 0.
  - Special-case flags are registered alongside.
- S2 (normalize):
  - If sum[47] = 1: shift right 1, exp + 1, OR the dropped bit into sticky.
  - Else: lzc = leading zeros counted from bit46. Shift left by min(lzc, exp − 1) when exp > 0, and set exp −= shift.
  - If the shift stops at the exp − 1 limit, or exp == 0, the result is subnormal and encodes with exponent 0.
  - A subnormal sum that reaches bit46 encodes with exponent 1.
  - sum == 0 marks an exact zero.
- S3 (round/pack):
  - Field split: kept = [46:23], guard = bit22, sticky = |[21:0] plus sticky from S2.
  - Increment rules:
    - RNE: G && (S || LSB).
    - RTZ: never.
    - RDN: res_sign && (G || S).
    - RUP: !res_sign && (G || S).
    - RMM: G.
  - A mantissa carry-out after increment gives exp + 1.
  - NX = G || S.
  - If exp >= 255 after rounding: OF = 1, NX = 1. Result is ±inf for RNE/RMM and toward the rounding direction; otherwise ±0x7F7FFFFF.
  - UF = NX && (result is tiny, i.e. exponent 0 after rounding).
- Special-case priority:
  1. NaN → CANON_NAN, NV = 0 (sNaN not distinguishable at this point).
  2. inf1 && inf2 && sign1 != sign2 → CANON_NAN, NV = 1.
  3. inf1 → {sign1, 8'hFF, 0}.
  4. inf2 → {sign2, 8'hFF, 0}.
  5. res_zero, or exact zero with differing signs → +0; −0 if rm = RDN. No flags.
  6. Exact zero with equal signs (zero path) → ±0 with sign1. No flags.
- Special results bypass rounding but still take 3 cycles.

Test Plan:
- 0x3F800000 + 0x3F800000, RNE → result 0x40000000 three cycles after accept, fflags 0.
- 0x3F800000 − 0x3F800000 (res_zero = 1): RNE → 0x00000000; RDN → 0x80000000. fflags 0 in both cases.
- 0x7F7FFFFF + 0x7F7FFFFF: RNE → 0x7F800000, fflags 5'b00101. RTZ → 0x7F7FFFFF, same flags.
- +inf + −inf → 0x7FC00000, fflags 5'b10000.
- Subnormal 0x00000001 + 0x00000001 → 0x00000002, fflags 0.
- 0x3F800000 + 0x33800000 (exact tie): RNE → 0x3F800000; RUP → 0x3F800001. fflags 5'b00001 in both cases.
- Stream 5 adds with out_ready held low for 4 cycles:
  - in_ready drops once the pipe is full.
  - result is held stable while stalled.
  - All 5 results emerge in order, none lost or duplicated.
- Assert reset_n low with 2 bundles in flight → out_valid = 0 immediately, and neither bundle appears after release.

Source files
------------

// File: rtl/fadd_sub_norm_round.sv
// -----------------------------------------------------------------------------
// fadd_sub_norm_round
//
// Back half of the binary32 add/sub datapath. Takes the aligned mantissas,
// common exponent and special-case flags from the extract/align stage. It then
// performs the magnitude add/sub, normalization, rounding and packing.
//
// Pipeline: three register stages that all advance together.
//   S1 : magnitude add/sub, result sign, special-case result selection
//   S2 : normalization (carry right-shift or leading-zero left-shift)
//   S3 : rounding, overflow/underflow handling, packing -> result/fflags
//
// Handshake (both sides are valid/ready):
//   A transfer happens on a rising edge where valid && ready are both high.
//   in_ready = advance = !out_valid || out_ready. in_ready does not depend on
//   in_valid. On advance every stage register loads from the stage before it.
//   While out_valid && !out_ready, every stage holds and result/fflags stay
//   stable.
//
// Ports:
//   clk, reset_n            core clock, asynchronous active-low reset
//   in_valid / in_ready     operand bundle handshake
//   rm[2:0]                 rounding mode (RNE, RTZ, RDN, RUP, RMM; others RNE)
//   sign1, sign2            operand signs (sign2 already carries add/sub)
//   exp_res[7:0]            common aligned exponent
//   mantissa1/2_aligned     [47] carry room, [46] hidden, [45:23] fraction,
//                           [22:0] bits shifted out during alignment
//   NaN, inf1, inf2, zero   operand classification
//   res_zero                exact cancellation detected upstream
//   out_valid / out_ready   result handshake
//   result[31:0]            packed binary32
//   fflags[4:0]             {NV, DZ, OF, UF, NX}; DZ is always 0
// -----------------------------------------------------------------------------
module fadd_sub_norm_round #(
  parameter int unsigned LATENCY   = 3,
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  rm,
  input  logic        sign1,
  input  logic        sign2,
  input  logic [7:0]  exp_res,
  input  logic [47:0] mantissa1_aligned,
  input  logic [47:0] mantissa2_aligned,
  input  logic        NaN,
  input  logic        inf1,
  input  logic        inf2,
  input  logic        zero,
  input  logic        res_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  fflags
);

  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // An exact-zero sum with equal signs can only come from two zero operands.
  // So the zero path is recognised from the sum itself and this flag is not
  // needed for any decision.
  logic unused_zero;
  assign unused_zero = zero;

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  logic [LATENCY-1:0] vld_q;
  logic               advance;

  assign out_valid = vld_q[LATENCY-1];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  // ---------------------------------------------------------------------------
  // S1: magnitude add/sub and special-case selection
  // ---------------------------------------------------------------------------
  logic [47:0] s1_sum_d,       s1_sum_q;
  logic        s1_sign_d,      s1_sign_q;
  logic [7:0]  s1_exp_q;
  logic [2:0]  s1_rm_q;
  logic        s1_spec_d,      s1_spec_q;
  logic [31:0] s1_spec_res_d,  s1_spec_res_q;
  logic [4:0]  s1_spec_flg_d,  s1_spec_flg_q;
  logic        m1_gt_m2;
  logic        sum_zero;

  always_comb begin
    s1_sum_d      = '0;
    s1_sign_d     = sign1;
    s1_spec_d     = 1'b0;
    s1_spec_res_d = '0;
    s1_spec_flg_d = '0;
    m1_gt_m2      = mantissa1_aligned > mantissa2_aligned;

    if (sign1 == sign2) begin
      s1_sum_d  = mantissa1_aligned + mantissa2_aligned;
      s1_sign_d = sign1;
    end else if (m1_gt_m2) begin
      s1_sum_d  = mantissa1_aligned - mantissa2_aligned;
      s1_sign_d = sign1;
    end else if (mantissa1_aligned != mantissa2_aligned) begin
      s1_sum_d  = mantissa2_aligned - mantissa1_aligned;
      s1_sign_d = sign2;
    end

    sum_zero = (s1_sum_d == '0);

    // Priority order matters: NaN beats inf-inf, which beats single infinities.
    if (NaN) begin
      s1_spec_d     = 1'b1;
      s1_spec_res_d = CANON_NAN;
    end else if (inf1 && inf2 && (sign1 != sign2)) begin
      s1_spec_d     = 1'b1;
      s1_spec_res_d = CANON_NAN;
      s1_spec_flg_d = 5'b10000;
    end else if (inf1) begin
      s1_spec_d     = 1'b1;
      s1_spec_res_d = {sign1, 8'hFF, 23'd0};
    end else if (inf2) begin
      s1_spec_d     = 1'b1;
      s1_spec_res_d = {sign2, 8'hFF, 23'd0};
    end else if (res_zero || (sum_zero && (sign1 != sign2))) begin
      // Cancellation yields +0, except -0 when rounding toward -inf.
      s1_spec_d     = 1'b1;
      s1_spec_res_d = {(rm == RM_RDN), 31'd0};
    end else if (sum_zero) begin
      s1_spec_d     = 1'b1;
      s1_spec_res_d = {sign1, 31'd0};
    end
  end

  // ---------------------------------------------------------------------------
  // S2: normalization
  // ---------------------------------------------------------------------------
  logic [5:0]  lzc;
  logic [8:0]  e_eff;
  logic [8:0]  shift_lim;
  logic [5:0]  shamt;
  logic [46:0] s2_mant_d,      s2_mant_q;
  logic [8:0]  s2_exp_d,       s2_exp_q;
  logic        s2_sticky_d,    s2_sticky_q;
  logic        s2_sign_q;
  logic [2:0]  s2_rm_q;
  logic        s2_spec_q;
  logic [31:0] s2_spec_res_q;
  logic [4:0]  s2_spec_flg_q;

  always_comb begin
    // Leading zeros counted from bit 46; the highest set bit wins.
    lzc = 6'd47;
    for (int i = 0; i < 47; i++) begin
      if (s1_sum_q[i]) lzc = 6'(46 - i);
    end

    // Exponent 0 carries the same scale as exponent 1 (subnormal range).
    e_eff       = (s1_exp_q == 8'd0) ? 9'd1 : {1'b0, s1_exp_q};
    shift_lim   = e_eff - 9'd1;
    shamt       = '0;
    s2_mant_d   = s1_sum_q[46:0];
    s2_exp_d    = e_eff;
    s2_sticky_d = 1'b0;

    if (s1_sum_q[47]) begin
      s2_mant_d   = s1_sum_q[47:1];
      s2_exp_d    = e_eff + 9'd1;
      s2_sticky_d = s1_sum_q[0];
    end else begin
      // Never shift below exponent 1; what is left stays subnormal.
      shamt     = ({3'd0, lzc} > shift_lim) ? shift_lim[5:0] : lzc;
      s2_mant_d = s1_sum_q[46:0] << shamt;
      s2_exp_d  = e_eff - {3'd0, shamt};
    end

    // Without the hidden bit the value is subnormal and encodes exponent 0.
    if (!s2_mant_d[46]) s2_exp_d = '0;
  end

  // ---------------------------------------------------------------------------
  // S3: rounding and packing
  // ---------------------------------------------------------------------------
  logic [23:0] kept;
  logic        guard_b;
  logic        sticky_b;
  logic        inc;
  logic        ovf_to_inf;
  logic [24:0] kept_r;
  logic [8:0]  exp_r;
  logic        nx;
  logic [31:0] result_d;
  logic [4:0]  fflags_d;

  always_comb begin
    kept     = s2_mant_q[46:23];
    guard_b  = s2_mant_q[22];
    sticky_b = (|s2_mant_q[21:0]) | s2_sticky_q;
    nx       = guard_b || sticky_b;

    case (s2_rm_q)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s2_sign_q && nx;
      RM_RUP:  inc = !s2_sign_q && nx;
      RM_RMM:  inc = guard_b;
      default: inc = guard_b && (sticky_b || kept[0]);
    endcase

    // Overflow goes to infinity unless the mode rounds toward zero for this sign.
    case (s2_rm_q)
      RM_RTZ:  ovf_to_inf = 1'b0;
      RM_RDN:  ovf_to_inf = s2_sign_q;
      RM_RUP:  ovf_to_inf = !s2_sign_q;
      default: ovf_to_inf = 1'b1;
    endcase

    kept_r = {1'b0, kept} + {24'd0, inc};
    // A normal mantissa carrying out, or a subnormal one rounding up into the
    // hidden bit, each bump the exponent by one.
    exp_r  = s2_exp_q + {8'd0, kept_r[24]}
                      + {8'd0, (s2_exp_q == 9'd0) && kept_r[23]};

    result_d = {s2_sign_q, exp_r[7:0], kept_r[22:0]};
    fflags_d = {3'b000, nx && (exp_r == 9'd0), nx};

    if (exp_r >= 9'd255) begin
      fflags_d = 5'b00101;
      result_d = ovf_to_inf ? {s2_sign_q, 8'hFF, 23'd0}
                            : {s2_sign_q, 8'hFE, 23'h7FFFFF};
    end

    if (s2_spec_q) begin
      result_d = s2_spec_res_q;
      fflags_d = s2_spec_flg_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q         <= '0;
      s1_sum_q      <= '0;
      s1_sign_q     <= 1'b0;
      s1_exp_q      <= '0;
      s1_rm_q       <= '0;
      s1_spec_q     <= 1'b0;
      s1_spec_res_q <= '0;
      s1_spec_flg_q <= '0;
      s2_mant_q     <= '0;
      s2_exp_q      <= '0;
      s2_sticky_q   <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_rm_q       <= '0;
      s2_spec_q     <= 1'b0;
      s2_spec_res_q <= '0;
      s2_spec_flg_q <= '0;
      result        <= '0;
      fflags        <= '0;
    end else if (advance) begin
      vld_q         <= {vld_q[LATENCY-2:0], in_valid};
      s1_sum_q      <= s1_sum_d;
      s1_sign_q     <= s1_sign_d;
      s1_exp_q      <= exp_res;
      s1_rm_q       <= rm;
      s1_spec_q     <= s1_spec_d;
      s1_spec_res_q <= s1_spec_res_d;
      s1_spec_flg_q <= s1_spec_flg_d;
      s2_mant_q     <= s2_mant_d;
      s2_exp_q      <= s2_exp_d;
      s2_sticky_q   <= s2_sticky_d;
      s2_sign_q     <= s1_sign_q;
      s2_rm_q       <= s1_rm_q;
      s2_spec_q     <= s1_spec_q;
      s2_spec_res_q <= s1_spec_res_q;
      s2_spec_flg_q <= s1_spec_flg_q;
      result        <= result_d;
      fflags        <= fflags_d;
    end
  end

endmodule
